// File: rtl/mux_serializer8_pkg.sv
// Shared types and constants for the 8-bit parallel-to-serial stage.
package mux_ser_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {IDLE, SHIFT} ser_state_e;

  typedef logic [SEL_W-1:0] sel_t;

  // Select value used for the first bit of a word.
  function automatic sel_t first_sel(input bit lsb_first);
    return lsb_first ? sel_t'(0) : sel_t'(DATA_W - 1);
  endfunction

  // Select value used for the final bit of a word.
  function automatic sel_t last_sel(input bit lsb_first);
    return lsb_first ? sel_t'(DATA_W - 1) : sel_t'(0);
  endfunction

  // One select step in the serialization direction; never called on the last bit.
  function automatic sel_t step_sel(input sel_t sel, input bit lsb_first);
    return lsb_first ? sel_t'(sel + sel_t'(1)) : sel_t'(sel - sel_t'(1));
  endfunction

endpackage

// File: rtl/mux_serializer8_if.sv
// Handshake bundle between a word producer, the serializer and the bit consumer.
interface mux_serializer8_if;
  import mux_ser_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_bit;
  logic              out_last;
  logic              out_ready;
  sel_t              sel_o;
  logic              busy;

  // Environment side: supplies words, consumes bits.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_last, sel_o, busy
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_last, sel_o, busy
  );

endinterface

// File: rtl/mux_serializer8_mux.sv
// 8:1 bit multiplexer: y = d[sel], built as a one-hot AND-OR tree.
module mux8to1
  import mux_ser_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  input  sel_t              sel,
  output logic              y
);

  logic [DATA_W-1:0] hit;

  // Each leg passes its data bit only when the select matches its position.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_leg
    assign hit[gi] = (sel == sel_t'(gi)) & d[gi];
  end

  assign y = |hit;

endmodule

// File: rtl/mux_serializer8.sv
// Parallel-to-serial stage: registers one word per input handshake and walks
// the mux8to1 select across all eight positions, one per accepted output beat.
module mux_serializer8
  import mux_ser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  mux_serializer8_if.slave bus
);

  localparam sel_t FIRST_SEL = first_sel(LSB_FIRST);
  localparam sel_t LAST_SEL  = last_sel(LSB_FIRST);

  ser_state_e        state_reg, state_next;
  logic [DATA_W-1:0] data_reg, data_next;
  sel_t              sel_reg, sel_next;

  logic out_valid;
  logic at_last;
  logic beat_xfer;
  logic in_ready;
  logic word_accept;
  logic mux_y;

  // Handshake terms. in_ready sees out_ready combinationally so a new word
  // can be taken on the last-beat cycle and streaming runs without a bubble.
  assign out_valid   = (state_reg == SHIFT);
  assign at_last     = (sel_reg == LAST_SEL);
  assign beat_xfer   = out_valid && bus.out_ready;
  assign in_ready    = !rst && ((state_reg == IDLE) || (beat_xfer && at_last));
  assign word_accept = bus.in_valid && in_ready;

  // The bit itself comes from the shared mux primitive.
  mux8to1 u_mux (
    .d   (data_reg),
    .sel (sel_reg),
    .y   (mux_y)
  );

  // Next-state logic: load on accepted words, step the select on accepted beats.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;
    unique case (state_reg)
      IDLE: begin
        if (word_accept) begin
          data_next  = bus.in_data;
          sel_next   = FIRST_SEL;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_xfer) begin
          if (at_last) begin
            // Select stays on the last position if no follow-on word arrives.
            if (word_accept) begin
              data_next  = bus.in_data;
              sel_next   = FIRST_SEL;
              state_next = SHIFT;
            end else begin
              state_next = IDLE;
            end
          end else begin
            sel_next = step_sel(sel_reg, LSB_FIRST);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, data and select registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      sel_reg   <= sel_next;
    end
  end

  // Outputs are forced quiet while idle; sel_o keeps showing the last select.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_valid & mux_y;
  assign bus.out_last  = out_valid & at_last;
  assign bus.sel_o     = sel_reg;
  assign bus.busy      = out_valid;

endmodule

// File: tb/tb_mux_serializer8.sv
// Directed bench for mux_serializer8: one LSB-first and one MSB-first instance.
module tb_mux_serializer8;
  import mux_ser_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  mux_serializer8_if a_if ();
  mux_serializer8_if b_if ();

  mux_serializer8 #(.LSB_FIRST(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  mux_serializer8 #(.LSB_FIRST(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic wait_cyc();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] word;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = 8'h00; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = 8'h00; b_if.out_ready = 1'b1;

    // 1: reset held two cycles
    wait_cyc();
    chk("rst_in_ready_a", {7'b0, a_if.in_ready}, 8'd0);
    chk("rst_in_ready_b", {7'b0, b_if.in_ready}, 8'd0);
    wait_cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", {7'b0, a_if.out_valid}, 8'd0);
    chk("post_rst_bit",   {7'b0, a_if.out_bit},   8'd0);
    chk("post_rst_sel",   {5'b0, a_if.sel_o},     8'd0);
    chk("post_rst_busy",  {7'b0, a_if.busy},      8'd0);
    chk("post_rst_ready", {7'b0, a_if.in_ready},  8'd1);
    $display("txn reset done");

    // 2: LSB-first 8'hA5 with no backpressure
    word = 8'hA5;
    a_if.in_valid = 1'b1; a_if.in_data = word;
    wait_cyc();
    a_if.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("a5_valid", {7'b0, a_if.out_valid}, 8'd1);
      chk("a5_bit",   {7'b0, a_if.out_bit},   {7'b0, word[k]});
      chk("a5_sel",   {5'b0, a_if.sel_o},     8'(k));
      chk("a5_last",  {7'b0, a_if.out_last},  {7'b0, k == 7});
      wait_cyc();
    end
    chk("a5_idle_valid", {7'b0, a_if.out_valid}, 8'd0);
    chk("a5_idle_busy",  {7'b0, a_if.busy},      8'd0);
    chk("a5_idle_sel",   {5'b0, a_if.sel_o},     8'd7);
    $display("txn word a5 lsb-first done");

    // 3: backpressure held for 3 cycles at sel 3
    a_if.in_valid = 1'b1; a_if.in_data = 8'hA5;
    wait_cyc();
    a_if.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_pre_sel", {5'b0, a_if.sel_o}, 8'(k));
      wait_cyc();
    end
    chk("bp_sel3", {5'b0, a_if.sel_o}, 8'd3);
    a_if.out_ready = 1'b0;
    for (int h = 0; h < 2; h++) begin
      wait_cyc();
      chk("bp_hold_sel",   {5'b0, a_if.sel_o},     8'd3);
      chk("bp_hold_bit",   {7'b0, a_if.out_bit},   8'd0);
      chk("bp_hold_valid", {7'b0, a_if.out_valid}, 8'd1);
      chk("bp_hold_last",  {7'b0, a_if.out_last},  8'd0);
    end
    a_if.out_ready = 1'b1;
    wait_cyc();
    for (int k = 4; k < 8; k++) begin
      chk("bp_resume_sel",  {5'b0, a_if.sel_o},    8'(k));
      chk("bp_resume_bit",  {7'b0, a_if.out_bit},  {7'b0, word[k]});
      chk("bp_resume_last", {7'b0, a_if.out_last}, {7'b0, k == 7});
      wait_cyc();
    end
    chk("bp_idle", {7'b0, a_if.out_valid}, 8'd0);
    $display("txn backpressure word a5 done");

    // 4: back-to-back FF then 00
    a_if.in_valid = 1'b1; a_if.in_data = 8'hFF;
    wait_cyc();
    a_if.in_data = 8'h00;
    for (int j = 1; j <= 16; j++) begin
      if (j == 9) a_if.in_valid = 1'b0;
      chk("b2b_valid", {7'b0, a_if.out_valid}, 8'd1);
      chk("b2b_bit",   {7'b0, a_if.out_bit},   {7'b0, j <= 8});
      chk("b2b_last",  {7'b0, a_if.out_last},  {7'b0, (j == 8) || (j == 16)});
      chk("b2b_ready", {7'b0, a_if.in_ready},  {7'b0, (j == 8) || (j == 16)});
      wait_cyc();
    end
    chk("b2b_idle", {7'b0, a_if.out_valid}, 8'd0);
    $display("txn back-to-back ff/00 done");

    // 5: reset after 4 bits of 3C, then 81 from bit 0
    word = 8'h3C;
    a_if.in_valid = 1'b1; a_if.in_data = word;
    wait_cyc();
    a_if.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("mid_bit", {7'b0, a_if.out_bit}, {7'b0, word[k]});
      wait_cyc();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {7'b0, a_if.in_ready}, 8'd0);
    wait_cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {7'b0, a_if.out_valid}, 8'd0);
    chk("mid_rst_last",  {7'b0, a_if.out_last},  8'd0);
    chk("mid_rst_sel",   {5'b0, a_if.sel_o},     8'd0);
    word = 8'h81;
    a_if.in_valid = 1'b1; a_if.in_data = word;
    wait_cyc();
    a_if.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("w81_bit",  {7'b0, a_if.out_bit},  {7'b0, (k == 0) || (k == 7)});
      chk("w81_sel",  {5'b0, a_if.sel_o},    8'(k));
      chk("w81_last", {7'b0, a_if.out_last}, {7'b0, k == 7});
      wait_cyc();
    end
    chk("w81_idle", {7'b0, a_if.out_valid}, 8'd0);
    $display("txn reset mid-word then 81 done");

    // rst and in_valid together: nothing captured
    rst = 1'b1;
    a_if.in_valid = 1'b1; a_if.in_data = 8'h55;
    wait_cyc();
    rst = 1'b0;
    a_if.in_valid = 1'b0;
    wait_cyc();
    chk("rst_wins_busy", {7'b0, a_if.busy}, 8'd0);
    $display("txn rst+in_valid collision done");

    // 6: MSB-first instance, 8'h01
    b_if.in_valid = 1'b1; b_if.in_data = 8'h01;
    wait_cyc();
    b_if.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("msb_sel",  {5'b0, b_if.sel_o},    8'(7 - k));
      chk("msb_bit",  {7'b0, b_if.out_bit},  {7'b0, k == 7});
      chk("msb_last", {7'b0, b_if.out_last}, {7'b0, k == 7});
      wait_cyc();
    end
    chk("msb_idle_valid", {7'b0, b_if.out_valid}, 8'd0);
    chk("msb_idle_sel",   {5'b0, b_if.sel_o},     8'd0);
    $display("txn word 01 msb-first done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
